// File: rtl/sha_nonce_feeder.sv
// Work feeder for sha256_2_pipeline: streams {tail, nonce} blocks one per cycle
// and carries each nonce through a latency-matched tag line to the pipeline output.
module sha_nonce_feeder #(
    parameter int PIPE_LAT = 64,
    parameter int NONCE_W  = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   work_valid,
    output logic                   work_ready,
    input  logic [255:0]           work_midstate,
    input  logic [95:0]            work_tail,
    input  logic [NONCE_W-1:0]     nonce_start,
    input  logic [NONCE_W-1:0]     nonce_end,
    input  logic                   abort,
    output logic                   pipe_write_en,
    output logic [255:0]           pipe_digest_init,
    output logic [255:0]           pipe_digest_in,
    output logic [95+NONCE_W:0]    pipe_block,
    output logic [NONCE_W-1:0]     nonce_tag,
    output logic                   nonce_tag_valid,
    output logic                   done,
    output logic [NONCE_W:0]       issued_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 accept_s;
    logic                 last_s;
    logic                 abort_s;
    logic                 tag_done_s;

    logic                 work_ready_r;
    logic                 pipe_write_en_r;
    logic [255:0]         midstate_r;
    logic [95:0]          tail_r;
    logic [NONCE_W-1:0]   nonce_cur_r;
    logic [NONCE_W-1:0]   nonce_end_r;
    logic [NONCE_W:0]     issued_count_r;

    logic [PIPE_LAT-1:0]  tag_valid_r;
    logic [PIPE_LAT-1:0]  tag_last_r;
    logic [NONCE_W-1:0]   tag_nonce_r [PIPE_LAT];

    assign tag_done_s = tag_valid_r[PIPE_LAT-1] & tag_last_r[PIPE_LAT-1];

    // Next-state decode; abort outranks the last-issue transition.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (work_valid && work_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                last_s  = (nonce_cur_r == nonce_end_r);
                abort_s = abort;
                if (abort) begin
                    state_s = IDLE;
                end else if (last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                abort_s = abort;
                if (abort) begin
                    state_s = IDLE;
                end else if (tag_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state, handshake flags and the latched work unit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r         <= IDLE;
            work_ready_r    <= 1'b0;
            pipe_write_en_r <= 1'b0;
            midstate_r      <= 256'd0;
            tail_r          <= 96'd0;
            nonce_cur_r     <= '0;
            nonce_end_r     <= '0;
            issued_count_r  <= '0;
        end else begin
            state_r         <= state_s;
            work_ready_r    <= (state_s == IDLE);
            pipe_write_en_r <= (state_s == RUN);
            if (accept_s) begin
                midstate_r     <= work_midstate;
                tail_r         <= work_tail;
                nonce_cur_r    <= nonce_start;
                nonce_end_r    <= nonce_end;
                issued_count_r <= '0;
            end else if (state_r == RUN) begin
                nonce_cur_r    <= nonce_cur_r + NONCE_W'(1);
                issued_count_r <= issued_count_r + (NONCE_W+1)'(1);
            end
        end
    end

    // Tag valid/last line; abort wipes every valid bit so nothing stale emerges.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_valid_r <= '0;
            tag_last_r  <= '0;
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_valid_r[i] <= abort_s ? 1'b0 : tag_valid_r[i-1];
                tag_last_r[i]  <= tag_last_r[i-1];
            end
            tag_valid_r[0] <= abort_s ? 1'b0 : pipe_write_en_r;
            tag_last_r[0]  <= last_s;
        end
    end

    // Tag nonce line, shifted in lockstep with the valid/last bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_nonce_r[i] <= '0;
            end
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_nonce_r[i] <= tag_nonce_r[i-1];
            end
            tag_nonce_r[0] <= nonce_cur_r;
        end
    end

    assign work_ready       = work_ready_r;
    assign pipe_write_en    = pipe_write_en_r;
    assign pipe_digest_init = midstate_r;
    assign pipe_digest_in   = midstate_r;
    assign pipe_block       = {tail_r, nonce_cur_r};
    assign nonce_tag        = tag_nonce_r[PIPE_LAT-1];
    assign nonce_tag_valid  = tag_valid_r[PIPE_LAT-1];
    assign done             = tag_done_s;
    assign issued_count     = issued_count_r;

endmodule

// File: tb/tb_sha_nonce_feeder.sv
// Scoreboard bench for sha_nonce_feeder: stimulus queues expected writes/tags,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_sha_nonce_feeder;

    localparam int LAT = 64;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         work_valid = 1'b0;
    logic         work_ready;
    logic [255:0] work_midstate = 256'd0;
    logic [95:0]  work_tail = 96'd0;
    logic [31:0]  nonce_start = 32'd0;
    logic [31:0]  nonce_end = 32'd0;
    logic         abort = 1'b0;
    logic         pipe_write_en;
    logic [255:0] pipe_digest_init;
    logic [255:0] pipe_digest_in;
    logic [127:0] pipe_block;
    logic [31:0]  nonce_tag;
    logic         nonce_tag_valid;
    logic         done;
    logic [32:0]  issued_count;

    sha_nonce_feeder #(.PIPE_LAT(LAT), .NONCE_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_tail(work_tail),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .abort(abort),
        .pipe_write_en(pipe_write_en), .pipe_digest_init(pipe_digest_init),
        .pipe_digest_in(pipe_digest_in), .pipe_block(pipe_block),
        .nonce_tag(nonce_tag), .nonce_tag_valid(nonce_tag_valid),
        .done(done), .issued_count(issued_count)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int last_write_cyc = 0;

    logic [383:0] wq [$];
    logic [32:0]  tq [$];
    int           wcyc [$];

    localparam logic [255:0] MID_A = 256'hF59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771;
    localparam logic [95:0]  TAIL_A = 96'h252db801130dae516461011a;
    localparam logic [255:0] MID_B = {8{32'h01234567}};
    localparam logic [95:0]  TAIL_B = 96'hcafef00d_11223344_55667788;
    localparam logic [255:0] MID_C = {8{32'h89abcdef}};
    localparam logic [95:0]  TAIL_C = 96'h0badc0de_99aabbcc_ddeeff00;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [127:0] blk, input logic [255:0] mid);
        wq.push_back({blk, mid});
    endtask

    task automatic push_t(input logic [31:0] n, input logic last);
        tq.push_back({last, n});
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops expectations whenever a write or a tag is presented.
    logic [383:0] mw;
    logic [32:0]  mt;
    int           mc;
    always @(negedge CLK) begin
        if (!RST) begin
            if (pipe_write_en) begin
                chk("write_expected", 384'(wq.size() != 0), 384'd1);
                if (wq.size() != 0) begin
                    mw = wq.pop_front();
                    chk("pipe_block", 384'(pipe_block), 384'(mw[383:256]));
                    chk("digest_in", 384'(pipe_digest_in), 384'(mw[255:0]));
                    chk("digest_init", 384'(pipe_digest_init), 384'(mw[255:0]));
                end
                wcyc.push_back(cyc);
                last_write_cyc = cyc;
            end
            if (nonce_tag_valid) begin
                chk("tag_expected", 384'(tq.size() != 0), 384'd1);
                if (tq.size() != 0) begin
                    mt = tq.pop_front();
                    chk("nonce_tag", 384'(nonce_tag), 384'(mt[31:0]));
                    chk("done_with_tag", 384'(done), 384'(mt[32]));
                end
                chk("tag_has_write", 384'(wcyc.size() != 0), 384'd1);
                if (wcyc.size() != 0) begin
                    mc = wcyc.pop_front();
                    chk("tag_latency", 384'(cyc - mc), 384'(LAT));
                end
            end else if (done) begin
                chk("done_without_tag", 384'(done), 384'd0);
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic send_work(input logic [255:0] mid, input logic [95:0] tail,
                             input logic [31:0] s, input logic [31:0] e);
        bit rdy = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (work_ready) begin
                rdy = 1'b1;
                break;
            end
            @(negedge CLK); #1;
        end
        chk("ready_before_send", 384'(rdy), 384'd1);
        work_midstate = mid; work_tail = tail; nonce_start = s; nonce_end = e;
        work_valid = 1'b1;
        @(negedge CLK); #1;
        work_valid = 1'b0;
        work_midstate = ~mid; work_tail = ~tail; nonce_start = ~s; nonce_end = ~e;
    endtask

    task automatic wait_done(input string name);
        int s = done_cnt;
        bit got = 1'b0;
        for (int k = 0; k < 4 * LAT; k++) begin
            @(negedge CLK); #1;
            if (done_cnt > s) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 384'(got), 384'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tv;
        int d1;
        int dc;
        // Reset state
        #1 RST = 1'b1;
        #2;
        chk("rst_work_ready", 384'(work_ready), 384'd0);
        chk("rst_write_en", 384'(pipe_write_en), 384'd0);
        chk("rst_tag_valid", 384'(nonce_tag_valid), 384'd0);
        chk("rst_done", 384'(done), 384'd0);
        chk("rst_issued", 384'(issued_count), 384'd0);
        @(negedge CLK); @(negedge CLK); #1;
        RST = 1'b0;
        chk("ready_before_first_edge", 384'(work_ready), 384'd0);
        @(negedge CLK); #1;
        chk("ready_after_release", 384'(work_ready), 384'd1);

        // abort while idle is ignored
        abort = 1'b1;
        @(negedge CLK); #1;
        abort = 1'b0;
        chk("idle_abort_ready", 384'(work_ready), 384'd1);

        // Single nonce
        push_w(128'h252db801130dae516461011a3aeb9bb8, MID_A);
        push_t(32'h3aeb9bb8, 1'b1);
        send_work(MID_A, TAIL_A, 32'h3aeb9bb8, 32'h3aeb9bb8);
        wait_done("single");
        chk("single_issued", 384'(issued_count), 384'd1);

        // Range 0..3
        push_w({TAIL_B, 32'h00000000}, MID_B); push_t(32'h00000000, 1'b0);
        push_w({TAIL_B, 32'h00000001}, MID_B); push_t(32'h00000001, 1'b0);
        push_w({TAIL_B, 32'h00000002}, MID_B); push_t(32'h00000002, 1'b0);
        push_w({TAIL_B, 32'h00000003}, MID_B); push_t(32'h00000003, 1'b1);
        send_work(MID_B, TAIL_B, 32'h00000000, 32'h00000003);
        wait_done("range");
        chk("range_ready_during_done", 384'(work_ready), 384'd0);
        @(negedge CLK); #1;
        chk("range_ready_after_done", 384'(work_ready), 384'd1);
        chk("range_issued", 384'(issued_count), 384'd4);

        // Wrap FFFFFFFE..00000001
        push_w({TAIL_C, 32'hFFFFFFFE}, MID_C); push_t(32'hFFFFFFFE, 1'b0);
        push_w({TAIL_C, 32'hFFFFFFFF}, MID_C); push_t(32'hFFFFFFFF, 1'b0);
        push_w({TAIL_C, 32'h00000000}, MID_C); push_t(32'h00000000, 1'b0);
        push_w({TAIL_C, 32'h00000001}, MID_C); push_t(32'h00000001, 1'b1);
        send_work(MID_C, TAIL_C, 32'hFFFFFFFE, 32'h00000001);
        wait_done("wrap");
        chk("wrap_issued", 384'(issued_count), 384'd4);

        // Abort after two writes of range 0..9
        push_w({TAIL_B, 32'h00000000}, MID_B);
        push_w({TAIL_B, 32'h00000001}, MID_B);
        send_work(MID_B, TAIL_B, 32'h00000000, 32'h00000009);
        @(negedge CLK); #1;
        abort = 1'b1;
        @(negedge CLK); #1;
        abort = 1'b0;
        chk("abort_write_en", 384'(pipe_write_en), 384'd0);
        chk("abort_ready", 384'(work_ready), 384'd1);
        dc = done_cnt;
        tv = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge CLK); #1;
            if (nonce_tag_valid || done) tv++;
        end
        chk("abort_no_tags", 384'(tv), 384'd0);
        chk("abort_no_done", 384'(done_cnt), 384'(dc));
        chk("abort_ready_end", 384'(work_ready), 384'd1);
        chk("abort_writes_consumed", 384'(wq.size()), 384'd0);
        wcyc.delete();

        // Async reset mid-RUN after three writes
        push_w({TAIL_C, 32'h00000000}, MID_C);
        push_w({TAIL_C, 32'h00000001}, MID_C);
        push_w({TAIL_C, 32'h00000002}, MID_C);
        send_work(MID_C, TAIL_C, 32'h00000000, 32'h00000009);
        @(negedge CLK); #1;
        @(negedge CLK); #1;
        chk("pre_reset_write_en", 384'(pipe_write_en), 384'd1);
        #2 RST = 1'b1;
        #1;
        chk("areset_write_en", 384'(pipe_write_en), 384'd0);
        chk("areset_tag_valid", 384'(nonce_tag_valid), 384'd0);
        chk("areset_ready", 384'(work_ready), 384'd0);
        chk("areset_issued", 384'(issued_count), 384'd0);
        @(negedge CLK); #1;
        RST = 1'b0;
        wcyc.delete();
        chk("areset_writes_consumed", 384'(wq.size()), 384'd0);
        push_w(128'h252db801130dae516461011a3aeb9bb8, MID_A);
        push_t(32'h3aeb9bb8, 1'b1);
        send_work(MID_A, TAIL_A, 32'h3aeb9bb8, 32'h3aeb9bb8);
        wait_done("post_reset_single");
        chk("post_reset_issued", 384'(issued_count), 384'd1);

        // Back-to-back with work_valid held high
        push_w({TAIL_B, 32'h00000000}, MID_B); push_t(32'h00000000, 1'b0);
        push_w({TAIL_B, 32'h00000001}, MID_B); push_t(32'h00000001, 1'b0);
        push_w({TAIL_B, 32'h00000002}, MID_B); push_t(32'h00000002, 1'b0);
        push_w({TAIL_B, 32'h00000003}, MID_B); push_t(32'h00000003, 1'b1);
        push_w({TAIL_C, 32'h00000100}, MID_C); push_t(32'h00000100, 1'b1);
        @(negedge CLK); #1;
        chk("b2b_ready", 384'(work_ready), 384'd1);
        work_midstate = MID_B; work_tail = TAIL_B;
        nonce_start = 32'h00000000; nonce_end = 32'h00000003;
        work_valid = 1'b1;
        @(negedge CLK); #1;
        work_midstate = MID_C; work_tail = TAIL_C;
        nonce_start = 32'h00000100; nonce_end = 32'h00000100;
        wait_done("b2b_first");
        d1 = last_done_cyc;
        wait_done("b2b_second");
        work_valid = 1'b0;
        chk("b2b_second_write_cycle", 384'(last_write_cyc), 384'(d1 + 2));
        chk("b2b_issued", 384'(issued_count), 384'd1);
        repeat (4) @(negedge CLK);
        #1;
        chk("final_ready", 384'(work_ready), 384'd1);
        chk("final_write_q_empty", 384'(wq.size()), 384'd0);
        chk("final_tag_q_empty", 384'(tq.size()), 384'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
